// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the MIPS-style write-back path.
//               Holds the wb_sel source encodings and the hard-wired zero
//               register index.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Write-back source select
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,  // alu_lo
    WB_HI   = 2'b01,  // architectural HI
    WB_LO   = 2'b10,  // architectural LO
    WB_LINK = 2'b11   // jal/jalr return address
  } wb_sel_e;

  // Register $0 is hard-wired to zero and never written
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/hilo_reg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_reg
// Description : Architectural HI/LO register pair written by mult/multu.
// Ports       : clk, rst (sync, active-high)
//               we          - load hi_d/lo_d on this edge
//               hi_d, lo_d  - next HI/LO values
//               hi_q, lo_q  - current HI/LO values
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] hi_d,
  input  logic [WIDTH-1:0] lo_d,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule : hilo_reg
`default_nettype wire

// File: rtl/ex_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_wb_stage
// Description : EX -> WB pipeline register with HI/LO, write-back source
//               select, forwarding compare and retired-instruction counter.
// Ports       : clk, rst (sync, active-high)
//               in_valid, stall, flush          - pipeline control
//               alu_lo, alu_hi, hilo_we         - ALU results / mult write
//               wb_sel, link_addr               - write-back source select
//               reg_we, rd_addr, rs_addr, rt_addr
//               wb_we, wb_addr, wb_data         - register-file write port
//               hi_q, lo_q                      - architectural HI/LO
//               fwd_rs, fwd_rt                  - bypass hits for EX operands
//               retire_cnt                      - retired instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module ex_wb_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic             hilo_we,
  input  logic [1:0]       wb_sel,
  input  logic [WIDTH-1:0] link_addr,
  input  logic             reg_we,
  input  logic [4:0]       rd_addr,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic             wb_we,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             fwd_rs,
  output logic             fwd_rt,
  output logic [31:0]      retire_cnt
);

  logic             valid_q,      valid_d;
  logic             reg_we_q,     reg_we_d;
  logic [4:0]       rd_q,         rd_d;
  logic [WIDTH-1:0] data_q,       data_d;
  logic [31:0]      retire_cnt_q, retire_cnt_d;
  logic [WIDTH-1:0] sel_data;
  logic             hilo_load;

  // HI/LO are read here before the edge that may overwrite them, so an
  // mfhi/mflo sees the value from before any mult in the same cycle.
  always_comb begin
    sel_data = alu_lo;
    case (wb_sel)
      WB_ALU:  sel_data = alu_lo;
      WB_HI:   sel_data = hi_q;
      WB_LO:   sel_data = lo_q;
      WB_LINK: sel_data = link_addr;
    endcase
  end

  // A killed or bubble instruction must never touch HI/LO.
  assign hilo_load = in_valid & hilo_we & ~stall & ~flush;

  always_comb begin
    valid_d      = valid_q;
    reg_we_d     = reg_we_q;
    rd_d         = rd_q;
    data_d       = data_q;
    retire_cnt_d = retire_cnt_q;
    // flush overrides stall: the valid bit is cleared even while held
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
    end
    if (!stall) begin
      reg_we_d = reg_we;
      rd_d     = rd_addr;
      data_d   = sel_data;
      if (valid_q) begin
        retire_cnt_d = retire_cnt_q + 32'd1;  // wraps naturally at 2^32
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_we_q     <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_we_q     <= reg_we_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  hilo_reg #(
    .WIDTH (WIDTH)
  ) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .we   (hilo_load),
    .hi_d (alu_hi),
    .lo_d (alu_lo),
    .hi_q (hi_q),
    .lo_q (lo_q)
  );

  assign wb_we      = valid_q & reg_we_q & (rd_q != REG_ZERO);
  assign wb_addr    = rd_q;
  assign wb_data    = data_q;
  assign retire_cnt = retire_cnt_q;
  assign fwd_rs     = wb_we & (rd_q == rs_addr);
  assign fwd_rt     = wb_we & (rd_q == rt_addr);

endmodule : ex_wb_stage
`default_nettype wire

// File: tb/tb_ex_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_wb_stage
// Description : Self-checking bench for ex_wb_stage. A behavioural model
//               tracks the instruction last handed to WB and the
//               architectural HI/LO/retire state; a negedge process compares
//               it with the DUT every cycle, and directed scenarios pin key
//               values with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_wb_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid, stall, flush, hilo_we, reg_we;
  logic [31:0] alu_lo, alu_hi, link_addr;
  logic [1:0]  wb_sel;
  logic [4:0]  rd_addr, rs_addr, rt_addr;
  logic        wb_we, fwd_rs, fwd_rt;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, hi_q, lo_q, retire_cnt;

  int checks   = 0;
  int failures = 0;

  ex_wb_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .alu_lo     (alu_lo),
    .alu_hi     (alu_hi),
    .hilo_we    (hilo_we),
    .wb_sel     (wb_sel),
    .link_addr  (link_addr),
    .reg_we     (reg_we),
    .rd_addr    (rd_addr),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .hi_q       (hi_q),
    .lo_q       (lo_q),
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks "the instruction now sitting in WB" and the
  // architectural HI/LO and retire count, following the stage's rules.
  logic        m_init = 1'b0;
  logic        m_valid, m_regwe, m_known, m_live;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_hi, m_lo, m_cnt, m_res;
  logic        preload;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_valid = 1'b0; m_regwe = 1'b0; m_addr = 5'd0;
      m_data = 32'd0; m_hi = 32'd0; m_lo = 32'd0; m_cnt = 32'd0; m_known = 1'b1;
    end else if (m_init) begin
      m_live = in_valid && !flush;
      if (preload) m_cnt = 32'hFFFF_FFFF;
      // the instruction leaving WB retires if the pipe advances
      if (!stall && m_valid) m_cnt = m_cnt + 32'd1;
      if (!stall) begin
        case (wb_sel)
          2'd0:    m_res = alu_lo;
          2'd1:    m_res = m_hi;
          2'd2:    m_res = m_lo;
          default: m_res = link_addr;
        endcase
        m_regwe = reg_we; m_addr = rd_addr; m_data = m_res; m_known = m_live;
        if (m_live && hilo_we) begin
          m_hi = alu_hi; m_lo = alu_lo;
        end
      end
      if (flush) m_valid = 1'b0;
      else if (!stall) m_valid = in_valid;
    end
  end

  logic exp_we;
  always @(negedge clk) begin
    if (m_init) begin
      exp_we = m_valid && m_regwe && (m_addr != 5'd0);
      chk("model wb_we",  {31'd0, wb_we},  {31'd0, exp_we});
      chk("model fwd_rs", {31'd0, fwd_rs}, {31'd0, exp_we && (m_addr == rs_addr)});
      chk("model fwd_rt", {31'd0, fwd_rt}, {31'd0, exp_we && (m_addr == rt_addr)});
      chk("model hi_q",   hi_q, m_hi);
      chk("model lo_q",   lo_q, m_lo);
      chk("model retire", retire_cnt, m_cnt);
      if (m_known) begin
        chk("model wb_addr", {27'd0, wb_addr}, {27'd0, m_addr});
        chk("model wb_data", wb_data, m_data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic ins(input logic v, input logic hw, input logic rw, input logic [1:0] sel,
                     input logic [4:0] rd, input logic [31:0] lo, input logic [31:0] hi);
    in_valid = v; hilo_we = hw; reg_we = rw; wb_sel = sel;
    rd_addr = rd; alu_lo = lo; alu_hi = hi;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; preload = 1'b0;
    rs_addr = 5'd0; rt_addr = 5'd0; link_addr = 32'd0;
    ins(1'b0, 1'b0, 1'b0, WB_ALU, 5'd0, 32'd0, 32'd0);
    tick(); tick();
    chk("reset wb_we",   {31'd0, wb_we}, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset hi",      hi_q, 32'd0);
    chk("reset lo",      lo_q, 32'd0);
    chk("reset retire",  retire_cnt, 32'd0);
    rst = 1'b0;

    // mult then mfhi
    ins(1'b1, 1'b1, 1'b0, WB_ALU, 5'd0, 32'hFFFF_FFFE, 32'h0000_0001); tick();
    chk("mult hi", hi_q, 32'h1);
    chk("mult lo", lo_q, 32'hFFFF_FFFE);
    ins(1'b1, 1'b0, 1'b1, WB_HI, 5'd8, 32'd0, 32'd0); tick();
    chk("mfhi data", wb_data, 32'h1);
    chk("mfhi we",   {31'd0, wb_we}, 32'd1);
    chk("mfhi addr", {27'd0, wb_addr}, 32'd8);
    chk("mfhi retire", retire_cnt, 32'd1);

    // mflo
    ins(1'b1, 1'b0, 1'b1, WB_LO, 5'd2, 32'd0, 32'd0); tick();
    chk("mflo data", wb_data, 32'hFFFF_FFFE);

    // mult with HI selected in the same instruction: sees the old HI
    ins(1'b1, 1'b1, 1'b1, WB_HI, 5'd3, 32'h5555, 32'hAAAA); tick();
    chk("old hi select", wb_data, 32'h1);
    chk("mult2 hi", hi_q, 32'hAAAA);

    // jal link
    link_addr = 32'h0000_0400;
    ins(1'b1, 1'b0, 1'b1, WB_LINK, 5'd31, 32'd0, 32'd0); tick();
    chk("link data", wb_data, 32'h400);

    // forwarding
    rs_addr = 5'd9; rt_addr = 5'd0;
    ins(1'b1, 1'b0, 1'b1, WB_ALU, 5'd9, 32'h55, 32'd0); tick();
    chk("fwd_rs", {31'd0, fwd_rs}, 32'd1);
    chk("fwd_rt", {31'd0, fwd_rt}, 32'd0);

    // write to $0 suppressed but still retires
    ins(1'b1, 1'b0, 1'b1, WB_ALU, 5'd0, 32'h1234, 32'd0); tick();
    chk("r0 we", {31'd0, wb_we}, 32'd0);
    chk("r0 retire before", retire_cnt, 32'd6);
    ins(1'b0, 1'b0, 1'b0, WB_ALU, 5'd0, 32'd0, 32'd0); tick();
    chk("r0 retire after", retire_cnt, 32'd7);

    // stall held 3 cycles over a captured add to r5
    ins(1'b1, 1'b0, 1'b1, WB_ALU, 5'd5, 32'h77, 32'd0); tick();
    chk("add5 data", wb_data, 32'h77);
    stall = 1'b1;
    ins(1'b1, 1'b1, 1'b1, WB_ALU, 5'd12, 32'h99, 32'h99);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall data",   wb_data, 32'h77);
      chk("stall we",     {31'd0, wb_we}, 32'd1);
      chk("stall retire", retire_cnt, 32'd7);
      chk("stall hi",     hi_q, 32'hAAAA);
    end

    // flush together with stall on a mult
    flush = 1'b1;
    ins(1'b1, 1'b1, 1'b1, WB_ALU, 5'd7, 32'hBEEF, 32'hDEAD); tick();
    chk("flush we", {31'd0, wb_we}, 32'd0);
    chk("flush hi", hi_q, 32'hAAAA);
    chk("flush lo", lo_q, 32'h5555);
    flush = 1'b0; stall = 1'b0;

    // retire counter wrap
    ins(1'b1, 1'b0, 1'b1, WB_ALU, 5'd4, 32'h44, 32'd0); tick();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    preload = 1'b1;
    ins(1'b0, 1'b0, 1'b0, WB_ALU, 5'd0, 32'd0, 32'd0); tick();
    preload = 1'b0;
    chk("wrap retire", retire_cnt, 32'd0);

    // reset in the middle of a stall
    ins(1'b1, 1'b0, 1'b1, WB_ALU, 5'd6, 32'h66, 32'd0); tick();
    stall = 1'b1; rst = 1'b1; tick();
    chk("rst-stall we",     {31'd0, wb_we}, 32'd0);
    chk("rst-stall data",   wb_data, 32'd0);
    chk("rst-stall addr",   {27'd0, wb_addr}, 32'd0);
    chk("rst-stall hi",     hi_q, 32'd0);
    chk("rst-stall retire", retire_cnt, 32'd0);
    chk("rst-stall fwd_rs", {31'd0, fwd_rs}, 32'd0);
    rst = 1'b0; stall = 1'b0;
    ins(1'b0, 1'b0, 1'b0, WB_ALU, 5'd0, 32'd0, 32'd0); tick();
    chk("post-rst we",     {31'd0, wb_we}, 32'd0);
    chk("post-rst retire", retire_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ex_wb_stage
`default_nettype wire

// File: doc/ex_wb_stage.md
EX_WB_STAGE -- requirements
Module: ex_wb_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of every data port and register.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  EX stage holds a live instruction this cycle.
REQ-005 Port: stall  input  1  hold all state (WB stage not accepting).
REQ-006 Port: flush  input  1  kill the instruction presented by EX this cycle.
REQ-007 Port: alu_lo  input  WIDTH  ALU low result.
REQ-008 Port: alu_hi  input  WIDTH  ALU high result; meaningful only for multiply.
REQ-009 Port: hilo_we  input  1  instruction is mult/multu; write {HI,LO}.
REQ-010 Port: wb_sel  input  2  write-back source select: ALU, HI, LO, LINK.
REQ-011 Port: link_addr  input  WIDTH  return address for jal/jalr.
REQ-012 Port: reg_we  input  1  instruction writes the register file.
REQ-013 Port: rd_addr  input  5  destination register.
REQ-014 Port: rs_addr, rt_addr  input  5 each  EX source registers, for forwarding compare.
REQ-015 Port: wb_we  output  1  register-file write enable.
REQ-016 Port: wb_addr  output  5  register-file write address.
REQ-017 Port: wb_data  output  WIDTH  register-file write data.
REQ-018 Port: hi_q, lo_q  output  WIDTH each  architectural HI/LO.
REQ-019 Port: fwd_rs, fwd_rt  output  1 each  wb_data bypasses the rs/rt operand.
REQ-020 Port: retire_cnt  output  32  count of retired instructions.

Function
REQ-021 The stage SHALL capture in_valid, reg_we, rd_addr and the selected data on the clock edge when stall=0, giving 1-cycle latency.
REQ-022 wb_sel encoding SHALL be: 00 selects alu_lo; 01 selects hi_q; 10 selects lo_q; 11 selects link_addr.
REQ-023 The wb_sel choice SHALL be resolved at capture time, using the hi_q/lo_q values present before that edge.
REQ-024 flush=1 SHALL capture valid=0, SHALL suppress the HI/LO write, and SHALL take priority over stall.
REQ-025 stall=1 with flush=0 SHALL hold every register, including HI, LO and retire_cnt.
REQ-026 HI/LO SHALL update to alu_hi/alu_lo when in_valid=1, hilo_we=1, stall=0 and flush=0; otherwise HI/LO SHALL hold.
REQ-027 wb_we SHALL equal valid_q & reg_we_q & (wb_addr != 0); writes to $0 are never issued.
REQ-028 fwd_rs SHALL equal wb_we & (wb_addr == rs_addr), and fwd_rt SHALL be defined likewise; both are combinational from registered state.
REQ-029 retire_cnt SHALL increment by 1 on each edge where valid_q=1 and stall=0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 An instruction with in_valid=0 SHALL behave as a flush: no write, no HI/LO update.

Reset
REQ-031 On rst=1 at a clock edge, valid_q, wb_addr, wb_data, hi_q, lo_q and retire_cnt SHALL become 0, and rst SHALL override stall and flush.
REQ-032 Following from REQ-031, wb_we, fwd_rs and fwd_rt SHALL read 0 in the cycle after reset.
REQ-033 rst asserted mid-stall SHALL discard the held instruction; no write SHALL occur after rst is released.

Structure
REQ-034 The wb_sel encodings (WB_ALU, WB_HI, WB_LO, WB_LINK) SHALL live in shared package mips_pkg, alongside the register-0 constant.
REQ-035 The HI/LO pair SHALL be a sub-module, hilo_reg, with inputs clk, rst, we, hi_d and lo_d and outputs hi_q and lo_q.

Verification
REQ-036 Scenario: mult with alu_hi=0x00000001, alu_lo=0xFFFFFFFE, hilo_we=1, then mfhi (wb_sel=01, rd=8) -> hi_q=0x1 after edge 1; wb_data=0x1, wb_we=1, wb_addr=8 after edge 2.
REQ-037 Scenario: add with rd_addr=0, alu_lo=0x1234 -> wb_we=0; retire_cnt increments by 1.
REQ-038 Scenario: mult presented with flush=1 and stall=1 together -> hi_q/lo_q unchanged; valid_q=0 next cycle.
REQ-039 Scenario: stall held 3 cycles with a valid add to rd=5 captured -> wb_data, wb_we and retire_cnt stable for all 3 cycles.
REQ-040 Scenario: wb_addr=9 with wb_we=1, rs_addr=9, rt_addr=0 -> fwd_rs=1, fwd_rt=0.
REQ-041 Scenario: retire_cnt preloaded via 2^32-1 retirements (or force) plus one more -> retire_cnt=0; rst mid-stall -> all outputs 0 next cycle.
